axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 165 ++++++++++++++++
 tb/tb_axi_sram_slave.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3-style slave in front of a 2**ADDR_BITS x 32-bit word store.
// One burst in flight at a time; reads take priority over writes when both request together.
module axi_sram_slave #(
    parameter int BUS_WIDTH = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic                 aclk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] arid,
    input  logic [31:0]          araddr,
    input  logic [3:0]           arlen,
    input  logic [1:0]           arburst,
    input  logic [2:0]           arsize,
    input  logic [1:0]           arlock,
    input  logic [3:0]           arcache,
    input  logic [2:0]           arprot,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [BUS_WIDTH-1:0] rid,
    output logic [31:0]          rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready,
    input  logic [BUS_WIDTH-1:0] awid,
    input  logic [31:0]          awaddr,
    input  logic [3:0]           awlen,
    input  logic [1:0]           awburst,
    input  logic [2:0]           awsize,
    input  logic [1:0]           awlock,
    input  logic [3:0]           awcache,
    input  logic [2:0]           awprot,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [BUS_WIDTH-1:0] wid,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [BUS_WIDTH-1:0] bid,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready
);

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

    state_t               state, state_nxt;
    logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
    logic [31:0]          addr;
    logic [3:0]           len;
    logic [3:0]           beat;
    logic                 fixed;
    logic [BUS_WIDTH-1:0] id;
    logic                 err;

    logic        ar_hs, aw_hs, r_hs, w_hs, b_hs, last_beat;
    logic [31:0] next_addr, rd_addr;
    logic        rd_oor, wr_oor;
    logic        unused;

    assign unused = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid};

    assign ar_hs     = arvalid & arready;
    assign aw_hs     = awvalid & awready;
    assign r_hs      = rvalid & rready;
    assign w_hs      = wvalid & wready;
    assign b_hs      = bvalid & bready;
    assign last_beat = (beat == len);
    assign next_addr = fixed ? addr : addr + 32'd4;

    // In IDLE the first read word comes from araddr; afterwards it is the following beat.
    assign rd_addr = (state == IDLE) ? araddr : next_addr;
    assign rd_oor  = |rd_addr[31:ADDR_BITS+2];
    assign wr_oor  = |addr[31:ADDR_BITS+2];

    assign rid   = id;
    assign bid   = id;
    assign rlast = rvalid & last_beat;
    assign bresp = err ? 2'b10 : 2'b00;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        rvalid    = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (state)
            IDLE: begin
                arready = rst_n & (arvalid | ~awvalid);
                awready = rst_n & ~arvalid;
                if (arvalid)      state_nxt = RDATA;
                else if (awvalid) state_nxt = WDATA;
            end
            RDATA: begin
                rvalid = 1'b1;
                if (rready && last_beat) state_nxt = IDLE;
            end
            WDATA: begin
                wready = 1'b1;
                if (wvalid && last_beat) state_nxt = WRESP;
            end
            WRESP: begin
                bvalid = 1'b1;
                if (bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            len   <= '0;
            beat  <= '0;
            fixed <= 1'b0;
            id    <= '0;
            err   <= 1'b0;
            rdata <= '0;
            rresp <= '0;
        end else if (ar_hs || (r_hs && !last_beat)) begin
            if (ar_hs) begin
                addr  <= araddr;
                len   <= arlen;
                fixed <= (arburst == 2'b00);
                id    <= arid;
                beat  <= '0;
            end else begin
                addr <= next_addr;
                beat <= beat + 4'd1;
            end
            rdata <= rd_oor ? '0 : mem[rd_addr[ADDR_BITS+1:2]];
            rresp <= rd_oor ? 2'b10 : 2'b00;
        end else if (aw_hs) begin
            addr  <= awaddr;
            len   <= awlen;
            fixed <= (awburst == 2'b00);
            id    <= awid;
            beat  <= '0;
        end else if (w_hs) begin
            if (wr_oor || (wlast != last_beat)) err <= 1'b1;
            if (!last_beat) begin
                addr <= next_addr;
                beat <= beat + 4'd1;
            end
        end else if (b_hs) begin
            err <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_hs && !wr_oor && wstrb[i])
                mem[addr[ADDR_BITS+1:2]][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus random bursts
// compared against a word-array model of the store.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.BUS_WIDTH(4), .ADDR_BITS(10)) dut (
        .aclk(aclk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arsize(arsize), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awsize(awsize), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int errors = 0;

    bit   [31:0] mm [1024];
    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_id [16];
    int          unstable;
    logic        rv_first, rv_after;
    logic [1:0]  got_bresp;
    logic [3:0]  got_bid;

    function automatic logic [31:0] beat_addr(input logic [31:0] s, input logic [1:0] burst, input int b);
        return (burst == 2'b00) ? s : s + (32'(b) << 2);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'h0000_1000;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return in_range(a) ? mm[a[11:2]] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_range(a) ? 2'b00 : 2'b10;
    endfunction

    // Applies wr_data/wr_strb to the model; returns the expected bresp.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [3:0] len,
                                               input logic [1:0] burst, input int bad);
        bit e = (bad >= 0 && bad <= int'(len));
        for (int b = 0; b <= int'(len); b++) begin
            logic [31:0] ba = beat_addr(a, burst, b);
            if (!in_range(ba)) e = 1;
            else for (int k = 0; k < 4; k++)
                if (wr_strb[b][k]) mm[ba[11:2]][8*k +: 8] = wr_data[b][8*k +: 8];
        end
        return e ? 2'b10 : 2'b00;
    endfunction

    task automatic read_burst(input logic [31:0] a, input logic [3:0] len, input logic [1:0] burst,
                              input logic [3:0] id, input bit stall, input int abort);
        bit ok = 0;
        bit held = 0;
        logic [31:0] hv = '0;
        int b = 0;
        araddr = a; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (arready) begin ok = 1; break; end
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready got 0 required 1");
        end
        unstable = 0; rv_first = 0;
        for (int c = 0; c < 200 && b <= int'(len) && b != abort; c++) begin
            rready = stall ? (c % 2 == 1) : 1'b1;
            @(negedge aclk);
            if (c == 0) rv_first = rvalid;
            if (rvalid && rready) begin
                if (held && rdata !== hv) unstable++;
                got_data[b] = rdata; got_resp[b] = rresp; got_last[b] = rlast; got_id[b] = rid;
                held = 0; b++;
            end else if (rvalid) begin
                if (held && rdata !== hv) unstable++;
                held = 1; hv = rdata;
            end
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        rv_after = rvalid;
        if (b <= int'(len) && b != abort) begin
            checks++; errors++;
            $display("FAIL r_timeout: beats got %0d required %0d", b, int'(len) + 1);
        end
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [3:0] len, input logic [1:0] burst,
                               input logic [3:0] id, input int bad);
        bit ok = 0;
        awaddr = a; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (awready) begin ok = 1; break; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready got 0 required 1");
        end
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wr_data[b]; wstrb = wr_strb[b];
            wlast = (b == int'(len)) ^ (b == bad);
            wvalid = 1'b1;
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge aclk);
                if (wready) begin ok = 1; break; end
            end
            @(posedge aclk); #1;
            if (!ok) begin
                checks++; errors++;
                $display("FAIL w_timeout: wready got 0 required 1 on beat %0d", b);
            end
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        ok = 0; got_bresp = 2'bxx; got_bid = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bvalid) begin ok = 1; got_bresp = bresp; got_bid = bid; break; end
        end
        @(posedge aclk); #1;
        bready = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL b_timeout: bvalid got 0 required 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if ({arready, awready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b required 00", {arready, awready}); end
        checks++; if ({rvalid, wready, bvalid, rlast} !== 4'b0000) begin errors++; $display("FAIL rst_valid: got %b required 0000", {rvalid, wready, bvalid, rlast}); end
        checks++; if ({rid, bid, rresp, bresp, rdata} !== '0) begin errors++; $display("FAIL rst_payload: got %h required 0", {rid, bid, rresp, bresp, rdata}); end
        @(posedge aclk); #1;
        rst_n = 1'b1;
        @(negedge aclk);
        checks++; if ({arready, awready} !== 2'b11) begin errors++; $display("FAIL rst_release: ready got %b required 11", {arready, awready}); end
        @(posedge aclk); #1;
    endtask

    task automatic test_single();
        logic [1:0] eb;
        wr_data[0] = 32'hDEAD_BEEF; wr_strb[0] = 4'hF;
        eb = model_write(32'h10, 4'd0, 2'b01, -1);
        write_burst(32'h10, 4'd0, 2'b01, 4'h3, -1);
        checks++; if (got_bresp !== eb || eb !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b required 00", got_bresp); end
        checks++; if (got_bid !== 4'h3) begin errors++; $display("FAIL single_bid: got %h required 3", got_bid); end
        read_burst(32'h10, 4'd0, 2'b01, 4'h5, 1'b0, -1);
        checks++; if (got_data[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h required deadbeef", got_data[0]); end
        checks++; if ({got_resp[0], got_last[0]} !== 3'b001) begin errors++; $display("FAIL single_resp_last: got %b required 001", {got_resp[0], got_last[0]}); end
        checks++; if (got_id[0] !== 4'h5) begin errors++; $display("FAIL single_rid: got %h required 5", got_id[0]); end
        checks++; if ({rv_first, rv_after} !== 2'b10) begin errors++; $display("FAIL single_rvalid_timing: got %b required 10", {rv_first, rv_after}); end
    endtask

    task automatic test_incr_stall();
        logic [1:0] eb;
        for (int b = 0; b < 4; b++) begin wr_data[b] = 32'(b + 1); wr_strb[b] = 4'hF; end
        eb = model_write(32'h20, 4'd3, 2'b01, -1);
        write_burst(32'h20, 4'd3, 2'b01, 4'h1, -1);
        checks++; if (got_bresp !== eb) begin errors++; $display("FAIL incr_bresp: got %b required %b", got_bresp, eb); end
        read_burst(32'h20, 4'd3, 2'b01, 4'h9, 1'b1, -1);
        for (int b = 0; b < 4; b++) begin
            checks++; if (got_data[b] !== 32'(b + 1)) begin errors++; $display("FAIL incr_rdata[%0d]: got %h required %h", b, got_data[b], b + 1); end
            checks++; if (got_last[b] !== (b == 3)) begin errors++; $display("FAIL incr_rlast[%0d]: got %b required %b", b, got_last[b], b == 3); end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL incr_stall_stable: changes got %0d required 0", unstable); end
    endtask

    task automatic test_strobe();
        logic [1:0] eb;
        wr_data[0] = 32'h1122_3344; wr_strb[0] = 4'hF;
        eb = model_write(32'h30, 4'd0, 2'b01, -1);
        write_burst(32'h30, 4'd0, 2'b01, 4'h0, -1);
        wr_data[0] = 32'h0000_AB00; wr_strb[0] = 4'b0010;
        eb = model_write(32'h30, 4'd0, 2'b01, -1);
        write_burst(32'h30, 4'd0, 2'b01, 4'h0, -1);
        read_burst(32'h30, 4'd0, 2'b01, 4'h0, 1'b0, -1);
        checks++; if (got_data[0] !== 32'h1122_AB44 || got_data[0] !== exp_data(32'h30)) begin errors++; $display("FAIL strobe_rdata: got %h required 1122ab44", got_data[0]); end
    endtask

    task automatic test_collision();
        int aw_seen = 0;
        bit got = 0;
        logic [31:0] d = 'x;
        logic [1:0] eb;
        araddr = 32'h10; arlen = 4'd0; arburst = 2'b01; arid = 4'h7;
        awaddr = 32'h40; awlen = 4'd0; awburst = 2'b01; awid = 4'h2;
        arvalid = 1'b1; awvalid = 1'b1;
        @(negedge aclk);
        checks++; if ({arready, awready} !== 2'b10) begin errors++; $display("FAIL collide_ready: got %b required 10", {arready, awready}); end
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge aclk);
            if (awready) aw_seen++;
            if (rvalid) begin d = rdata; got = 1; end
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        checks++; if (aw_seen !== 0) begin errors++; $display("FAIL collide_awready_held: cycles got %0d required 0", aw_seen); end
        checks++; if (d !== exp_data(32'h10)) begin errors++; $display("FAIL collide_rdata: got %h required %h", d, exp_data(32'h10)); end
        wr_data[0] = $urandom; wr_strb[0] = 4'hF;
        eb = model_write(32'h40, 4'd0, 2'b01, -1);
        write_burst(32'h40, 4'd0, 2'b01, 4'h2, -1);
        checks++; if ({got_bresp, got_bid} !== {eb, 4'h2}) begin errors++; $display("FAIL collide_write: got %b/%h required %b/2", got_bresp, got_bid, eb); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] eb;
        read_burst(32'h1000, 4'd0, 2'b01, 4'h4, 1'b0, -1);
        checks++; if ({got_data[0], got_resp[0]} !== {32'h0, 2'b10}) begin errors++; $display("FAIL oor_read: got %h/%b required 0/10", got_data[0], got_resp[0]); end
        for (int b = 0; b < 2; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
        eb = model_write(32'h50, 4'd1, 2'b01, 0);
        write_burst(32'h50, 4'd1, 2'b01, 4'h6, 0);
        checks++; if (got_bresp !== 2'b10 || eb !== 2'b10) begin errors++; $display("FAIL wlast_err_bresp: got %b required 10", got_bresp); end
        for (int b = 0; b < 4; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
        eb = model_write(32'hFF8, 4'd3, 2'b01, -1);
        write_burst(32'hFF8, 4'd3, 2'b01, 4'h6, -1);
        checks++; if (got_bresp !== eb) begin errors++; $display("FAIL cross_bresp: got %b required %b", got_bresp, eb); end
        read_burst(32'hFF8, 4'd3, 2'b01, 4'h6, 1'b0, -1);
        for (int b = 0; b < 4; b++) begin
            logic [31:0] ba = beat_addr(32'hFF8, 2'b01, b);
            checks++; if ({got_data[b], got_resp[b]} !== {exp_data(ba), exp_resp(ba)}) begin errors++; $display("FAIL cross_read[%0d]: got %h/%b required %h/%b", b, got_data[b], got_resp[b], exp_data(ba), exp_resp(ba)); end
        end
        wr_data[0] = $urandom; wr_strb[0] = 4'hF;
        eb = model_write(32'h60, 4'd0, 2'b01, -1);
        write_burst(32'h60, 4'd0, 2'b01, 4'h6, -1);
        checks++; if (got_bresp !== eb) begin errors++; $display("FAIL err_cleared_bresp: got %b required %b", got_bresp, eb); end
    endtask

    task automatic test_random();
        logic [1:0] eb;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 16; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
            eb = model_write(32'(k * 64), 4'd15, 2'b01, -1);
            write_burst(32'(k * 64), 4'd15, 2'b01, 4'(k), -1);
            checks++; if (got_bresp !== eb) begin errors++; $display("FAIL fill_bresp[%0d]: got %b required %b", k, got_bresp, eb); end
        end
        for (int t = 0; t < 24; t++) begin
            logic [31:0] a = 32'($urandom_range(0, 47) * 4 + $urandom_range(0, 3));
            logic [3:0]  len = 4'($urandom_range(0, 15));
            logic [1:0]  burst = 2'($urandom_range(0, 3));
            logic [3:0]  id = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                int bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
                for (int b = 0; b < 16; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'($urandom); end
                eb = model_write(a, len, burst, bad);
                write_burst(a, len, burst, id, bad);
                checks++; if ({got_bresp, got_bid} !== {eb, id}) begin errors++; $display("FAIL rnd_write[%0d]: got %b/%h required %b/%h", t, got_bresp, got_bid, eb, id); end
            end else begin
                read_burst(a, len, burst, id, 1'($urandom), -1);
                for (int b = 0; b <= int'(len); b++) begin
                    logic [31:0] ba = beat_addr(a, burst, b);
                    checks++;
                    if ({got_data[b], got_resp[b], got_last[b], got_id[b]} !== {exp_data(ba), exp_resp(ba), (b == int'(len)), id}) begin
                        errors++;
                        $display("FAIL rnd_read[%0d.%0d]: got %h/%b/%b/%h required %h/%b/%b/%h", t, b,
                                 got_data[b], got_resp[b], got_last[b], got_id[b], exp_data(ba), exp_resp(ba), b == int'(len), id);
                    end
                end
                checks++; if (unstable !== 0) begin errors++; $display("FAIL rnd_stall_stable[%0d]: changes got %0d required 0", t, unstable); end
            end
        end
    endtask

    task automatic test_reset_mid();
        read_burst(32'h40, 4'd7, 2'b01, 4'hA, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        checks++; if ({rvalid, rlast} !== 2'b00) begin errors++; $display("FAIL midrst_rvalid: got %b required 00", {rvalid, rlast}); end
        repeat (2) @(posedge aclk);
        #1;
        rst_n = 1'b1;
        @(negedge aclk);
        checks++; if ({arready, awready} !== 2'b11) begin errors++; $display("FAIL midrst_release: ready got %b required 11", {arready, awready}); end
        @(posedge aclk); #1;
        read_burst(32'h40, 4'd7, 2'b01, 4'hB, 1'b0, -1);
        for (int b = 0; b < 8; b++) begin
            logic [31:0] ba = beat_addr(32'h40, 2'b01, b);
            checks++; if ({got_data[b], got_last[b], got_id[b]} !== {exp_data(ba), (b == 7), 4'hB}) begin errors++; $display("FAIL midrst_read[%0d]: got %h/%b/%h required %h/%b/b", b, got_data[b], got_last[b], got_id[b], exp_data(ba), b == 7); end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time got 500000 required less");
        $fatal(1);
    end

    initial begin
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arsize = 3'd2; arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awsize = 3'd2; awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        test_reset();
        test_single();
        test_incr_stall();
        test_strobe();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
